// File: rtl/alarm_controller.sv
// Alarm controller: per-zone sensor debounce feeding a four-state
// DISARMED / ARMED / ENTRY / ALARM machine with entry-delay countdown
// and a sticky record of the zones seen open while armed.
module alarm_controller #(
    parameter int N_ZONES                    = 5,
    parameter int DB_CYCLES                  = 4,
    parameter int ENTRY_CYCLES               = 16,
    parameter logic [N_ZONES-1:0] DELAY_MASK = N_ZONES'(1),
    localparam int CW                        = (ENTRY_CYCLES > 1) ? $clog2(ENTRY_CYCLES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_ZONES-1:0] sensor,
    input  logic [N_ZONES-1:0] zone_en,
    input  logic               arm,
    input  logic               disarm,
    output logic               alarm,
    output logic               armed,
    output logic               entry_pending,
    output logic [CW-1:0]      entry_count,
    output logic [N_ZONES-1:0] trip_zones
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(ENTRY_CYCLES - 1);

    typedef enum logic [1:0] {
        S_DISARMED,
        S_ARMED,
        S_ENTRY,
        S_ALARM
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_entryCount;
    logic                 r_alarm;
    logic                 r_armed;
    logic                 r_entryPending;
    logic [N_ZONES-1:0]   r_tripZones;
    logic [N_ZONES-1:0]   r_filtered;
    logic [DBW-1:0]       r_dbCnt [N_ZONES];

    state_t               w_nextState;
    logic [CW-1:0]        w_nextCount;
    logic [N_ZONES-1:0]   w_nextTrip;
    logic [N_ZONES-1:0]   w_active;
    logic [N_ZONES-1:0]   w_inst;
    logic [N_ZONES-1:0]   w_dly;

    // Debounce: a zone's filtered bit flips only once the raw input has
    // disagreed with it on DB_CYCLES consecutive edges; any agreement restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filtered <= '0;
            for (int z = 0; z < N_ZONES; z++) begin
                r_dbCnt[z] <= '0;
            end
        end else begin
            for (int z = 0; z < N_ZONES; z++) begin
                if (sensor[z] == r_filtered[z]) begin
                    r_dbCnt[z] <= '0;
                end else if (r_dbCnt[z] == DB_LAST) begin
                    r_filtered[z] <= sensor[z];
                    r_dbCnt[z]    <= '0;
                end else begin
                    r_dbCnt[z] <= r_dbCnt[z] + DBW'(1);
                end
            end
        end
    end

    assign w_active = r_filtered & zone_en;
    assign w_inst   = w_active & ~DELAY_MASK;
    assign w_dly    = w_active & DELAY_MASK;

    // Next-state decode; disarm is checked first in every armed state so it
    // always beats a simultaneous trip, and arm is only honoured when idle.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = '0;
        case (r_state)
            S_DISARMED: begin
                if (arm && !disarm && (w_active == '0)) begin
                    w_nextState = S_ARMED;
                end
            end
            S_ARMED: begin
                if (disarm) begin
                    w_nextState = S_DISARMED;
                end else if (w_inst != '0) begin
                    w_nextState = S_ALARM;
                end else if (w_dly != '0) begin
                    w_nextState = S_ENTRY;
                    w_nextCount = CNT_LOAD;
                end
            end
            S_ENTRY: begin
                if (disarm) begin
                    w_nextState = S_DISARMED;
                end else if (w_inst != '0) begin
                    w_nextState = S_ALARM;
                end else if (r_entryCount == '0) begin
                    w_nextState = S_ALARM;
                end else begin
                    w_nextCount = r_entryCount - CW'(1);
                end
            end
            S_ALARM: begin
                if (disarm) begin
                    w_nextState = S_DISARMED;
                end
            end
            default: begin
                w_nextState = S_DISARMED;
            end
        endcase
    end

    // Trip record accumulates while armed and is wiped when disarming.
    always_comb begin
        w_nextTrip = r_tripZones;
        if (w_nextState == S_DISARMED) begin
            w_nextTrip = '0;
        end else if (r_state != S_DISARMED) begin
            w_nextTrip = r_tripZones | w_active;
        end
    end

    // State, countdown and every output register update together, so no
    // input ever reaches an output without passing through a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_DISARMED;
            r_entryCount   <= '0;
            r_alarm        <= 1'b0;
            r_armed        <= 1'b0;
            r_entryPending <= 1'b0;
            r_tripZones    <= '0;
        end else begin
            r_state        <= w_nextState;
            r_entryCount   <= w_nextCount;
            r_alarm        <= (w_nextState == S_ALARM);
            r_armed        <= (w_nextState != S_DISARMED);
            r_entryPending <= (w_nextState == S_ENTRY);
            r_tripZones    <= w_nextTrip;
        end
    end

    assign alarm         = r_alarm;
    assign armed         = r_armed;
    assign entry_pending = r_entryPending;
    assign entry_count   = r_entryCount;
    assign trip_zones    = r_tripZones;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with default parameters: a vector
// table for glitch rejection, arm refusal and disarm priority, followed by
// hand-built sequences for entry countdown, escalation and async reset.
module tb_alarm_controller;

    typedef struct packed {
        logic [4:0]  sensor;
        logic [4:0]  zoneEn;
        logic        arm;
        logic        disarm;
        logic [11:0] expOut;
    } vec_t;

    logic       clk;
    logic       rstN;
    logic [4:0] sensor;
    logic [4:0] zoneEn;
    logic       arm;
    logic       disarm;
    logic       alarm;
    logic       armed;
    logic       entryPending;
    logic [3:0] entryCount;
    logic [4:0] tripZones;

    int vecCount  = 0;
    int missCount = 0;

    vec_t table_q[$];

    alarm_controller dut (
        .clk           (clk),
        .rst_n         (rstN),
        .sensor        (sensor),
        .zone_en       (zoneEn),
        .arm           (arm),
        .disarm        (disarm),
        .alarm         (alarm),
        .armed         (armed),
        .entry_pending (entryPending),
        .entry_count   (entryCount),
        .trip_zones    (tripZones)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs packed as {alarm, armed, entry_pending, entry_count, trip_zones}.
    function automatic vec_t mk(input logic [4:0] s, input logic [4:0] en,
                                input logic a, input logic d,
                                input logic expAlarm, input logic expArmed,
                                input logic expPend, input logic [3:0] expCnt,
                                input logic [4:0] expTrip);
        vec_t v;
        v.sensor = s;
        v.zoneEn = en;
        v.arm    = a;
        v.disarm = d;
        v.expOut = {expAlarm, expArmed, expPend, expCnt, expTrip};
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        sensor = v.sensor;
        zoneEn = v.zoneEn;
        arm    = v.arm;
        disarm = v.disarm;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [11:0] expVal);
        logic [11:0] actual;
        actual = {alarm, armed, entryPending, entryCount, tripZones};
        vecCount++;
        if (actual !== expVal) begin
            missCount++;
            $display("[TB] FAIL %s: alarm/armed/pend/cnt/trip got %b_%b_%b_%h_%b required %b_%b_%b_%h_%b",
                     name, actual[11], actual[10], actual[9], actual[8:5], actual[4:0],
                     expVal[11], expVal[10], expVal[9], expVal[8:5], expVal[4:0]);
        end
    endtask

    task automatic runVec(input string name, input vec_t v);
        applyStimulus(v);
        checkOutput(name, v.expOut);
    endtask

    initial begin
        // Glitch rejection on instant zone 2, then a real trip and disarm.
        table_q.push_back(mk(5'b00000, 5'b11111, 1, 0, 0, 1, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00100, 5'b11111, 0, 0, 0, 1, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00100, 5'b11111, 0, 0, 0, 1, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00100, 5'b11111, 0, 0, 0, 1, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00000, 5'b11111, 0, 0, 0, 1, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00100, 5'b11111, 0, 0, 0, 1, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00100, 5'b11111, 0, 0, 0, 1, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00100, 5'b11111, 0, 0, 0, 1, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00100, 5'b11111, 0, 0, 0, 1, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00100, 5'b11111, 0, 0, 1, 1, 0, 0, 5'b00100));
        table_q.push_back(mk(5'b00000, 5'b11111, 1, 0, 1, 1, 0, 0, 5'b00100));
        table_q.push_back(mk(5'b00000, 5'b11111, 0, 1, 0, 0, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00000, 5'b11111, 0, 0, 0, 0, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00000, 5'b11111, 0, 0, 0, 0, 0, 0, 5'b00000));
        // Arm refused while zone 1 is open, accepted once zone 1 is disabled.
        table_q.push_back(mk(5'b00010, 5'b11111, 0, 0, 0, 0, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00010, 5'b11111, 0, 0, 0, 0, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00010, 5'b11111, 0, 0, 0, 0, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00010, 5'b11111, 0, 0, 0, 0, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00010, 5'b11111, 1, 0, 0, 0, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00010, 5'b11101, 1, 0, 0, 1, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00010, 5'b11101, 0, 1, 0, 0, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00000, 5'b11111, 0, 0, 0, 0, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00000, 5'b11111, 0, 0, 0, 0, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00000, 5'b11111, 0, 0, 0, 0, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b00000, 5'b11111, 0, 0, 0, 0, 0, 0, 5'b00000));
        // Disarm lands on the same edge that a debounced zone 3 would trip.
        table_q.push_back(mk(5'b00000, 5'b11111, 1, 0, 0, 1, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b01000, 5'b11111, 0, 0, 0, 1, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b01000, 5'b11111, 0, 0, 0, 1, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b01000, 5'b11111, 0, 0, 0, 1, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b01000, 5'b11111, 0, 0, 0, 1, 0, 0, 5'b00000));
        table_q.push_back(mk(5'b01000, 5'b11111, 0, 1, 0, 0, 0, 0, 5'b00000));
        for (int i = 0; i < 4; i++) begin
            table_q.push_back(mk(5'b00000, 5'b11111, 0, 0, 0, 0, 0, 0, 5'b00000));
        end

        // Reset state and release; nothing may move before the next edge.
        rstN   = 1'b0;
        sensor = '0;
        zoneEn = 5'b11111;
        arm    = 1'b0;
        disarm = 1'b0;
        #12;
        checkOutput("resetState", 12'b0);
        arm  = 1'b1;
        rstN = 1'b1;
        #1;
        checkOutput("resetRelease", 12'b0);

        for (int i = 0; i < table_q.size(); i++) begin
            runVec($sformatf("vec%0d", i), table_q[i]);
        end

        // Full entry countdown; zone 0 closes and is then disabled mid-count.
        runVec("entryArm", mk(5'b00000, 5'b11111, 1, 0, 0, 1, 0, 0, 5'b00000));
        for (int i = 0; i < 4; i++) begin
            runVec("entryDebounce", mk(5'b00001, 5'b11111, 0, 0, 0, 1, 0, 0, 5'b00000));
        end
        runVec("entryStart", mk(5'b00001, 5'b11111, 0, 0, 0, 1, 1, 4'd15, 5'b00001));
        for (int k = 14; k >= 0; k--) begin
            logic [4:0] en;
            en = (k < 8) ? 5'b11110 : 5'b11111;
            runVec($sformatf("entryCount%0d", k), mk(5'b00000, en, 0, 0, 0, 1, 1, 4'(k), 5'b00001));
        end
        runVec("entryExpire", mk(5'b00000, 5'b11110, 0, 0, 1, 1, 0, 0, 5'b00001));
        runVec("entryDisarm", mk(5'b00000, 5'b11111, 0, 1, 0, 0, 0, 0, 5'b00000));

        // Entry cancelled by disarm while five clocks remain.
        runVec("cancelArm", mk(5'b00000, 5'b11111, 1, 0, 0, 1, 0, 0, 5'b00000));
        for (int i = 0; i < 4; i++) begin
            runVec("cancelDebounce", mk(5'b00001, 5'b11111, 0, 0, 0, 1, 0, 0, 5'b00000));
        end
        runVec("cancelStart", mk(5'b00001, 5'b11111, 0, 0, 0, 1, 1, 4'd15, 5'b00001));
        for (int k = 14; k >= 5; k--) begin
            runVec($sformatf("cancelCount%0d", k), mk(5'b00001, 5'b11111, 0, 0, 0, 1, 1, 4'(k), 5'b00001));
        end
        runVec("cancelDisarm", mk(5'b00001, 5'b11111, 0, 1, 0, 0, 0, 0, 5'b00000));
        for (int i = 0; i < 3; i++) begin
            runVec("cancelQuiet", mk(5'b00001, 5'b11111, 0, 0, 0, 0, 0, 0, 5'b00000));
        end
        for (int i = 0; i < 4; i++) begin
            runVec("cancelRelease", mk(5'b00000, 5'b11111, 0, 0, 0, 0, 0, 0, 5'b00000));
        end

        // Instant zone 4 opening during entry escalates straight to alarm.
        runVec("escArm", mk(5'b00000, 5'b11111, 1, 0, 0, 1, 0, 0, 5'b00000));
        for (int i = 0; i < 4; i++) begin
            runVec("escDebounce", mk(5'b00001, 5'b11111, 0, 0, 0, 1, 0, 0, 5'b00000));
        end
        runVec("escStart", mk(5'b00001, 5'b11111, 0, 0, 0, 1, 1, 4'd15, 5'b00001));
        for (int k = 14; k >= 11; k--) begin
            runVec($sformatf("escCount%0d", k), mk(5'b10001, 5'b11111, 0, 0, 0, 1, 1, 4'(k), 5'b00001));
        end
        runVec("escAlarm", mk(5'b10001, 5'b11111, 0, 0, 1, 1, 0, 0, 5'b10001));

        // Asynchronous reset in the middle of alarm, between clock edges.
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("resetAsync", 12'b0);
        sensor = '0;
        arm    = 1'b0;
        #2;
        rstN = 1'b1;
        runVec("postReset", mk(5'b00000, 5'b11111, 0, 0, 0, 0, 0, 0, 5'b00000));

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
